// File: rtl/pmod_keyb_pkg.sv
// pmod_keyb_pkg: shared constants and types for the PMOD matrix keyboard
// scanner and its debounced key map.
package pmod_keyb_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 7;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    SELECT,
    LOAD,
    SHIFT,
    NEXT
  } scan_state_e;

  // Key map indexed r*NUM_COLS+c, 0 = pressed.
  typedef logic [NUM_KEYS-1:0] keymap_t;

  // A low row strobe pulls its columns onto the shared column lines.
  function automatic logic [NUM_COLS-1:0] col_resp(
    input keymap_t             m,
    input logic [NUM_ROWS-1:0] rows
  );
    logic [NUM_COLS-1:0] acc;
    acc = '1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows[r]) acc = acc & m[r*NUM_COLS +: NUM_COLS];
    end
    return acc;
  endfunction

endpackage

// File: rtl/keyb_debounce_map.sv
// keyb_debounce_map: two-frame agreement filter over the raw key map,
// plus the any-key flag.
module keyb_debounce_map
  import pmod_keyb_pkg::*;
(
  input  logic    CLK25,
  input  logic    reset_n_i,
  input  logic    update,
  input  keymap_t raw,
  output keymap_t stable,
  output logic    key_any
);

  keymap_t prev_q;
  keymap_t stable_q;
  keymap_t stable_d;
  keymap_t agree;
  logic    key_any_q;

  assign agree = ~(raw ^ prev_q);

  always_comb begin
    stable_d = stable_q;
    if (update) stable_d = (raw & agree) | (stable_q & ~agree);
  end

  always_ff @(posedge CLK25 or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_q    <= '1;
      stable_q  <= '1;
      key_any_q <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      key_any_q <= ~&stable_d;
      if (update) prev_q <= raw;
    end
  end

  assign stable  = stable_q;
  assign key_any = key_any_q;

endmodule

// File: rtl/pmod_keyb_scanner.sv
// pmod_keyb_scanner: scans an 8x7 PMOD membrane via 74HC138/74HC165 and
// answers the core's active-low row strobes from a debounced key map.
module pmod_keyb_scanner
  import pmod_keyb_pkg::*;
#(
  parameter int CLK_DIV      = 25,
  parameter int SETTLE_TICKS = 4
) (
  input  logic                CLK25,
  input  logic                reset_n_i,
  input  logic [NUM_ROWS-1:0] keyb_row_i,
  output logic [NUM_COLS-1:0] keyb_col_o,
  output logic [2:0]          row_sel_o,
  output logic                sr_load_n_o,
  output logic                sr_clk_o,
  input  logic                sr_data_i,
  output logic                scan_done_o,
  output logic                key_any_o
);

  localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);

  scan_state_e state_q, state_d;
  logic [7:0]  div_q;
  logic        tick_q;
  logic [2:0]  row_q, row_d;
  logic [3:0]  set_q, set_d;
  logic [2:0]  bit_q, bit_d;
  logic        ph_q, ph_d;
  logic        load_n_q, load_n_d;
  logic        sr_clk_q, sr_clk_d;
  keymap_t     raw_q, raw_d;
  logic        frame_end;
  logic        done_q;
  logic [NUM_COLS-1:0] col_q;
  logic [5:0]  idx;
  keymap_t     stable;

  assign idx = 6'(row_q) * 6'd7 + 6'(bit_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    set_d     = set_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    load_n_d  = load_n_q;
    sr_clk_d  = sr_clk_q;
    raw_d     = raw_q;
    frame_end = 1'b0;
    if (tick_q) begin
      unique case (state_q)
        SELECT: begin
          if (set_q == SETTLE_LAST) begin
            set_d    = '0;
            load_n_d = 1'b0;
            state_d  = LOAD;
          end else begin
            set_d = set_q + 4'd1;
          end
        end
        LOAD: begin
          load_n_d = 1'b1;
          bit_d    = 3'd6;
          ph_d     = 1'b0;
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (!ph_q) begin
            raw_d[idx] = sr_data_i;
            sr_clk_d   = 1'b0;
            ph_d       = 1'b1;
          end else begin
            sr_clk_d = 1'b1;
            ph_d     = 1'b0;
            if (bit_q == 3'd0) state_d = NEXT;
            else bit_d = bit_q - 3'd1;
          end
        end
        NEXT: begin
          sr_clk_d  = 1'b0;
          row_d     = row_q + 3'd1;
          frame_end = (row_q == 3'd7);
          state_d   = SELECT;
        end
        default: state_d = SELECT;
      endcase
    end
  end

  always_ff @(posedge CLK25 or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q    <= '0;
      tick_q   <= 1'b0;
      state_q  <= SELECT;
      row_q    <= '0;
      set_q    <= '0;
      bit_q    <= '0;
      ph_q     <= 1'b0;
      load_n_q <= 1'b1;
      sr_clk_q <= 1'b0;
      raw_q    <= '1;
      done_q   <= 1'b0;
      col_q    <= '1;
    end else begin
      div_q    <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
      tick_q   <= (div_q == DIV_LAST);
      state_q  <= state_d;
      row_q    <= row_d;
      set_q    <= set_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      load_n_q <= load_n_d;
      sr_clk_q <= sr_clk_d;
      raw_q    <= raw_d;
      done_q   <= frame_end;
      col_q    <= col_resp(stable, keyb_row_i);
    end
  end

  keyb_debounce_map u_dbnc (
    .CLK25     (CLK25),
    .reset_n_i (reset_n_i),
    .update    (frame_end),
    .raw       (raw_q),
    .stable    (stable),
    .key_any   (key_any_o)
  );

  assign keyb_col_o  = col_q;
  assign row_sel_o   = row_q;
  assign sr_load_n_o = load_n_q;
  assign sr_clk_o    = sr_clk_q;
  assign scan_done_o = done_q;

endmodule
